mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multi-cycle main controller for the single-issue MIPS core.
- Sequences the instruction fetch unit and the rest of the datapath (IR, GRF, ALU, DM, MDU) through per-instruction phases.
- Drives the PC load enable and next-PC select into the fetch unit, and gives each instruction class its own cycle count.
- Sits beside the fetch unit at core top level. It reads opcode/funct from the instruction register output.

Parameters:
- MDU_WAIT_MAX, 64, upper bound on MDU_WAIT cycles. Reaching it raises ERR and forces the exit.
- NOP_ON_UNKNOWN, 1, 1 = an undecoded instruction retires after DECODE as a nop; 0 = it raises ERR as well.

Ports:
- clk  in  1  core clock; all state changes on rising edge
- RESET  in  1  synchronous active-high reset
- opcode  in  6  IR[31:26]; valid from DECODE onward
- funct  in  6  IR[5:0]; valid from DECODE onward
- MDU_BUSY  in  1  multiply/divide unit busy
- PC_EN  out  1  drives the fetch unit's STALL_EN_N; 1 = PC loads NPC this edge
- NPCSel  out  2  00 PC+4, 01 branch (offset, qualified by BranchComp), 10 jump (instr_index), 11 register
- IR_WE  out  1  instruction register load
- GRF_WE  out  1  register file write
- A3Sel  out  2  00 rt, 01 rd, 10 $31
- WDSel  out  2  00 ALU result, 01 DM read data, 10 PC+4
- ALUSrc  out  1  0 rt data, 1 extended imm
- EXTOp  out  1  0 zero-extend, 1 sign-extend
- ALUOp  out  3  000 add, 001 sub, 010 or, 011 lui-shift
- DM_WE  out  1  data memory write
- MDU_START  out  1  one-cycle start pulse; selects mult/div from funct
- STATE  out  3  current state, for debug
- ERR  out  1  sticky error flag; cleared only by RESET

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, MDU_WAIT=5. Encodings 6 and 7 go to FETCH on the next edge.
- Reset:
  - RESET sampled high forces state FETCH and ERR=0.
  - While RESET is high, all enables (PC_EN, IR_WE, GRF_WE, DM_WE, MDU_START) are forced to 0, overriding the state.
  - A reset mid-instruction abandons that instruction; no partial writes occur after the reset edge.
- Outputs are Moore/Mealy combinational functions of the registered state plus decoded class; none are registered.
- FETCH: IR_WE=1, all other enables 0. Next state is DECODE.
- PC_EN and NPCSel:
  - PC_EN=1 in exactly one cycle per instruction, the last cycle of that instruction. The PC therefore stays stable while the instruction executes.
  - NPCSel is valid only in the PC_EN cycle and is 00 otherwise.
- Class paths (cycles per instruction):
  - ALU R-type (addu 0x21, subu 0x23): FETCH, DECODE, EXEC, WB = 4. A3Sel=01.
  - ori (0x0D), lui (0x0F): FETCH, DECODE, EXEC, WB = 4. ALUSrc=1, EXTOp=0, A3Sel=00.
  - lw (0x23): FETCH, DECODE, EXEC, MEM, WB = 5. WDSel=01, EXTOp=1.
  - sw (0x2B): FETCH, DECODE, EXEC, MEM = 4. DM_WE=1 in MEM.
  - beq (0x04): FETCH, DECODE, EXEC = 3. PC_EN=1 with NPCSel=01 in EXEC.
  - j (0x02): FETCH, DECODE = 2. NPCSel=10.
  - jr (op 0, funct 0x08): FETCH, DECODE = 2. NPCSel=11.
  - jal (0x03): FETCH, DECODE, WB = 3. A3Sel=10, WDSel=10, NPCSel=10 in WB.
  - mult/div (op 0, funct 0x18/0x1A): FETCH, DECODE, EXEC (MDU_START=1), then MDU_WAIT.
- MDU_WAIT:
  - The cycle after EXEC is always MDU_WAIT, regardless of MDU_BUSY.
  - Stay while MDU_BUSY=1.
  - The first cycle MDU_BUSY=0 asserts PC_EN (NPCSel=00) and goes to FETCH.
  - An internal wait counter resets on MDU_WAIT entry. When it reaches MDU_WAIT_MAX-1 with MDU_BUSY still 1, set ERR and exit exactly as in the not-busy case.
- Unknown opcode/funct: retire at DECODE (PC_EN=1, NPCSel=00). If NOP_ON_UNKNOWN=0, also set ERR.
- GRF_WE=1 only in WB. DM_WE=1 only in MEM for sw. MDU_START=1 only in EXEC for mult/div.

Decomposition:
- Shared package mc_pkg:
  - state enum
  - NPCSel, A3Sel, WDSel and ALUOp code constants
  - opcode/funct constants
  - instruction-class enum (ALU_R, ORI, LUI, LW, SW, BEQ, J, JR, JAL, MDU, UNK)
- Sub-module mc_decode: purely combinational opcode/funct to class. The FSM and output logic stay in mc_ctrl.

Test Plan:
- Reset: RESET high 2 cycles mid-EXEC of a sw. Expect STATE=0, DM_WE=0 on the reset edge, and IR_WE=1 the first cycle after release.
- addu (op 0, funct 0x21): expect states 0,1,2,4. GRF_WE=1 and A3Sel=01 only in WB. PC_EN=1 only in WB with NPCSel=00.
- lw then sw back-to-back: expect 5 then 4 cycles, PC_EN pulses 5 cycles apart then 4 apart. DM_WE=1 only in the sw MEM cycle.
- beq and jal: beq gives PC_EN with NPCSel=01 in cycle 3. jal gives WB with A3Sel=10, WDSel=10, NPCSel=10.
- mult with MDU_BUSY high 5 cycles after EXEC: expect 5 MDU_WAIT cycles, then PC_EN=1 in the sixth MDU_WAIT cycle (first with MDU_BUSY=0). MDU_START is exactly one pulse.
- Stuck MDU: MDU_BUSY held 1 with MDU_WAIT_MAX=64. Expect ERR=1 and PC_EN=1 on the 64th MDU_WAIT cycle. Opcode 0x3F with NOP_ON_UNKNOWN=0 retires in 2 cycles and sets ERR.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: shared state, instruction-class and control-code definitions for the multi-cycle controller
package mc_pkg;
  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_DECODE   = 3'd1,
    S_EXEC     = 3'd2,
    S_MEM      = 3'd3,
    S_WB       = 3'd4,
    S_MDU_WAIT = 3'd5
  } state_e;
  typedef enum logic [3:0] {
    C_ALU_R, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JR, C_JAL, C_MDU, C_UNK
  } cls_e;
  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_REG = 2'b11;
  localparam logic [1:0] A3_RT   = 2'b00;
  localparam logic [1:0] A3_RD   = 2'b01;
  localparam logic [1:0] A3_RA   = 2'b10;
  localparam logic [1:0] WD_ALU  = 2'b00;
  localparam logic [1:0] WD_DM   = 2'b01;
  localparam logic [1:0] WD_PC4  = 2'b10;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_LUI = 3'b011;
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_DIV  = 6'h1A;
endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational opcode/funct to instruction-class decoder
module mc_decode import mc_pkg::*; (
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output cls_e       o_cls
);
  cls_e w_r_cls;
  always_comb begin
    w_r_cls = (i_funct == FN_ADDU || i_funct == FN_SUBU) ? C_ALU_R :
              (i_funct == FN_JR) ? C_JR :
              (i_funct == FN_MULT || i_funct == FN_DIV) ? C_MDU : C_UNK;
    o_cls = (i_opcode == OP_R)   ? w_r_cls :
            (i_opcode == OP_ORI) ? C_ORI :
            (i_opcode == OP_LUI) ? C_LUI :
            (i_opcode == OP_LW)  ? C_LW :
            (i_opcode == OP_SW)  ? C_SW :
            (i_opcode == OP_BEQ) ? C_BEQ :
            (i_opcode == OP_J)   ? C_J :
            (i_opcode == OP_JAL) ? C_JAL : C_UNK;
  end
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS main controller sequencing fetch, decode, execute, memory, writeback and MDU wait
module mc_ctrl import mc_pkg::*; #(
  parameter int MDU_WAIT_MAX   = 64,
  parameter bit NOP_ON_UNKNOWN = 1'b1
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       MDU_BUSY,
  output logic       PC_EN,
  output logic [1:0] NPCSel,
  output logic       IR_WE,
  output logic       GRF_WE,
  output logic [1:0] A3Sel,
  output logic [1:0] WDSel,
  output logic       ALUSrc,
  output logic       EXTOp,
  output logic [2:0] ALUOp,
  output logic       DM_WE,
  output logic       MDU_START,
  output logic [2:0] STATE,
  output logic       ERR
);
  localparam int CW = $clog2(MDU_WAIT_MAX + 1);
  logic [2:0]    r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic          r_err, w_mdu_exit, w_err_set, w_pc_en, w_wb;
  cls_e          w_cls;
  mc_decode u_dec (.i_opcode(opcode), .i_funct(funct), .o_cls(w_cls));
  always_comb begin
    w_mdu_exit = !MDU_BUSY || r_cnt == CW'(MDU_WAIT_MAX - 1);
    w_next = (r_state == S_FETCH)  ? S_DECODE :
             (r_state == S_DECODE) ? ((w_cls inside {C_J, C_JR, C_UNK}) ? S_FETCH : (w_cls == C_JAL) ? S_WB : S_EXEC) :
             (r_state == S_EXEC)   ? ((w_cls == C_BEQ) ? S_FETCH : (w_cls inside {C_LW, C_SW}) ? S_MEM :
                                      (w_cls == C_MDU) ? S_MDU_WAIT : S_WB) :
             (r_state == S_MEM)    ? ((w_cls == C_LW) ? S_WB : S_FETCH) :
             (r_state == S_MDU_WAIT && !w_mdu_exit) ? S_MDU_WAIT : S_FETCH;
    w_pc_en = !RESET && w_next == S_FETCH && r_state <= S_MDU_WAIT;
    w_wb = r_state == S_WB;
    w_err_set = !RESET && ((r_state == S_MDU_WAIT && MDU_BUSY && w_mdu_exit) ||
                           (!NOP_ON_UNKNOWN && r_state == S_DECODE && w_cls == C_UNK));
    PC_EN = w_pc_en;
    NPCSel = !w_pc_en ? NPC_PC4 :
             (r_state == S_DECODE) ? ((w_cls == C_J) ? NPC_J : (w_cls == C_JR) ? NPC_REG : NPC_PC4) :
             (r_state == S_EXEC && w_cls == C_BEQ) ? NPC_BR :
             (w_wb && w_cls == C_JAL) ? NPC_J : NPC_PC4;
    IR_WE = !RESET && r_state == S_FETCH;
    GRF_WE = !RESET && w_wb;
    DM_WE = !RESET && r_state == S_MEM && w_cls == C_SW;
    MDU_START = !RESET && r_state == S_EXEC && w_cls == C_MDU;
    A3Sel = !w_wb ? A3_RT : (w_cls == C_ALU_R) ? A3_RD : (w_cls == C_JAL) ? A3_RA : A3_RT;
    WDSel = !w_wb ? WD_ALU : (w_cls == C_LW) ? WD_DM : (w_cls == C_JAL) ? WD_PC4 : WD_ALU;
    ALUSrc = w_cls inside {C_ORI, C_LUI, C_LW, C_SW};
    EXTOp = w_cls inside {C_LW, C_SW};
    ALUOp = (w_cls == C_ALU_R) ? ((funct == FN_SUBU) ? ALU_SUB : ALU_ADD) :
            (w_cls == C_ORI) ? ALU_OR : (w_cls == C_LUI) ? ALU_LUI :
            (w_cls == C_BEQ) ? ALU_SUB : ALU_ADD;
    STATE = r_state;
    ERR = r_err | w_err_set;
  end
  always_ff @(posedge clk) begin
    if (RESET) begin
      r_state <= S_FETCH;
      r_err <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_err <= r_err | w_err_set;
      r_cnt <= (r_state == S_MDU_WAIT) ? r_cnt + 1'b1 : '0;
    end
  end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: randomized instruction streams checked against a per-instruction cycle-sequence model
module tb_mc_ctrl;
  logic clk = 1'b0, RESET = 1'b1, MDU_BUSY = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic pc_en, ir_we, grf_we, alusrc, extop, dm_we, mdu_start, err;
  logic [1:0] npc, a3, wd;
  logic [2:0] aluop, st;
  logic pc_en1, ir_we1, grf_we1, alusrc1, extop1, dm_we1, mdu_start1, err1;
  logic [1:0] npc1, a31, wd1;
  logic [2:0] aluop1, st1;
  int n_cmp = 0, n_bad = 0;
  logic err_exp0 = 1'b0, err_exp1 = 1'b0;
  logic [5:0] k_op [14] = '{6'h00, 6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h00, 6'h03, 6'h00, 6'h00, 6'h3F, 6'h00};
  logic [5:0] k_fn [14] = '{6'h21, 6'h23, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h00, 6'h18, 6'h1A, 6'h00, 6'h00};
  mc_ctrl #(.MDU_WAIT_MAX(64), .NOP_ON_UNKNOWN(1'b0)) dut (
    .clk(clk), .RESET(RESET), .opcode(opcode), .funct(funct), .MDU_BUSY(MDU_BUSY),
    .PC_EN(pc_en), .NPCSel(npc), .IR_WE(ir_we), .GRF_WE(grf_we), .A3Sel(a3), .WDSel(wd),
    .ALUSrc(alusrc), .EXTOp(extop), .ALUOp(aluop), .DM_WE(dm_we), .MDU_START(mdu_start),
    .STATE(st), .ERR(err));
  mc_ctrl dut_nop (
    .clk(clk), .RESET(RESET), .opcode(opcode), .funct(funct), .MDU_BUSY(MDU_BUSY),
    .PC_EN(pc_en1), .NPCSel(npc1), .IR_WE(ir_we1), .GRF_WE(grf_we1), .A3Sel(a31), .WDSel(wd1),
    .ALUSrc(alusrc1), .EXTOp(extop1), .ALUOp(aluop1), .DM_WE(dm_we1), .MDU_START(mdu_start1),
    .STATE(st1), .ERR(err1));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run(input int kind, input int busy);
    int seq[$];
    int nw, j;
    bit last, stuck, unk;
    string p;
    case (kind)
      0, 1, 2, 3: seq = '{0, 1, 2, 4};
      4: seq = '{0, 1, 2, 3, 4};
      5: seq = '{0, 1, 2, 3};
      6: seq = '{0, 1, 2};
      7, 8, 12, 13: seq = '{0, 1};
      9: seq = '{0, 1, 4};
      default: begin
        seq = '{0, 1, 2};
        nw = (busy + 1 < 64) ? busy + 1 : 64;
        for (int i = 0; i < nw; i++) seq.push_back(5);
      end
    endcase
    stuck = (kind == 10 || kind == 11) && busy >= 64;
    unk = kind >= 12;
    opcode = k_op[kind];
    funct = (k_op[kind] == 6'h00) ? k_fn[kind] : 6'($urandom);
    j = 0;
    for (int i = 0; i < seq.size(); i++) begin
      last = i == seq.size() - 1;
      if (seq[i] == 5) begin
        j++;
        MDU_BUSY = j <= busy;
      end else MDU_BUSY = 1'($urandom);
      if (last && stuck) begin
        err_exp0 = 1'b1;
        err_exp1 = 1'b1;
      end
      if (last && unk) err_exp0 = 1'b1;
      @(negedge clk);
      p = $sformatf("k%0d c%0d", kind, i);
      chk({p, " state"}, st, seq[i]);
      chk({p, " pc_en"}, pc_en, last);
      chk({p, " npcsel"}, npc, !last ? 0 : (kind == 7 || kind == 9) ? 2 : kind == 8 ? 3 : kind == 6 ? 1 : 0);
      chk({p, " ir_we"}, ir_we, seq[i] == 0);
      chk({p, " grf_we"}, grf_we, seq[i] == 4);
      chk({p, " dm_we"}, dm_we, seq[i] == 3 && kind == 5);
      chk({p, " mdu_start"}, mdu_start, seq[i] == 2 && kind >= 10 && kind <= 11);
      chk({p, " a3sel"}, a3, seq[i] != 4 ? 0 : kind <= 1 ? 1 : kind == 9 ? 2 : 0);
      chk({p, " wdsel"}, wd, seq[i] != 4 ? 0 : kind == 4 ? 1 : kind == 9 ? 2 : 0);
      chk({p, " err"}, err, err_exp0);
      chk({p, " nop state"}, st1, seq[i]);
      chk({p, " nop pc_en"}, pc_en1, last);
      chk({p, " nop err"}, err1, err_exp1);
      if (seq[i] == 2 && kind <= 6) begin
        chk({p, " alusrc"}, alusrc, kind >= 2 && kind <= 5);
        chk({p, " aluop"}, aluop, kind <= 3 ? kind : kind == 6 ? 1 : 0);
        if (kind >= 2 && kind <= 5) chk({p, " extop"}, extop, kind >= 4);
      end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic reset_mid_sw();
    opcode = 6'h2B;
    funct = 6'($urandom);
    repeat (2) @(posedge clk);
    #1;
    RESET = 1'b1;
    @(negedge clk);
    chk("rst exec state", st, 2);
    chk("rst dm_we", dm_we, 0);
    chk("rst pc_en", pc_en, 0);
    chk("rst grf_we", grf_we, 0);
    chk("rst ir_we", ir_we, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst edge state", st, 0);
    chk("rst edge dm_we", dm_we, 0);
    chk("rst edge ir_we", ir_we, 0);
    chk("rst edge err", err, 0);
    chk("rst edge nop err", err1, 0);
    err_exp0 = 1'b0;
    err_exp1 = 1'b0;
    @(posedge clk);
    #1;
    RESET = 1'b0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("init state", st, 0);
    chk("init pc_en", pc_en, 0);
    chk("init ir_we", ir_we, 0);
    chk("init mdu_start", mdu_start, 0);
    chk("init err", err, 0);
    @(posedge clk);
    #1;
    RESET = 1'b0;
    run(0, 0);
    run(4, 0);
    run(5, 0);
    run(6, 0);
    run(9, 0);
    run(10, 5);
    for (int n = 0; n < 40; n++) run($urandom_range(0, 11), $urandom_range(0, 8));
    run(11, 70);
    reset_mid_sw();
    run(12, 0);
    run(13, 0);
    run(7, 0);
    reset_mid_sw();
    run(1, 0);
    run(8, 0);
    run(3, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
